// File: rtl/fxp_norm_shifter_pkg.sv
// Shared types and helpers for the fixed-to-float converter.
// Holds the FSM encoding, exponent width/bias and offset helper.
package fxp2fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int EXP_W = 8;
  localparam int BIAS  = 127;

  function automatic logic [EXP_W-1:0] exp_offset(
    input int w,
    input int frac,
    input int cnt
  );
    return EXP_W'(w - 1 - frac - cnt);
  endfunction

endpackage

// File: rtl/fxp_norm_shifter_if.sv
// Handshake and data bundle of the normalizing shifter.
// master drives samples / consumes results, slave is the shifter.
interface fxp_norm_shifter_if #(
  parameter int W     = 32,
  parameter int M     = 23,
  parameter int EXP_W = 8
);
  logic             valid_in;
  logic             ready_in;
  logic [W-1:0]     data_in;
  logic             valid_out;
  logic             ready_out;
  logic             sign_out;
  logic             zero_out;
  logic [M-1:0]     mant_out;
  logic [EXP_W-1:0] exp_off;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, sign_out,
    input  zero_out, mant_out, exp_off
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, sign_out,
    output zero_out, mant_out, exp_off
  );
endinterface

// File: rtl/fxp_norm_shifter_abs.sv
// Combinational two's-complement magnitude, W bits in and out.
// The most-negative input maps to 2^(W-1) as an unsigned value.
module fxp_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = a_i[W-1] ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/fxp_norm_shifter.sv
// Normalizes a signed fixed-point word one bit per cycle and
// emits sign, zero flag, truncated mantissa and exponent offset.
module fxp_norm_shifter #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int M     = 23,
  parameter int EXP_W = fxp2fp_pkg::EXP_W
) (
  input logic              clk,
  input logic              rst,
  fxp_norm_shifter_if.slave bus
);
  import fxp2fp_pkg::*;

  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnr_q, sgnr_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic [M-1:0]     mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [W-1:0]     abs_w;

  fxp_abs #(.W(W)) u_abs (
    .a_i (bus.data_in),
    .y_o (abs_w)
  );

  assign bus.ready_in  = (state_q == S_IDLE);
  assign bus.valid_out = (state_q == S_DONE);
  assign bus.sign_out  = sign_q;
  assign bus.zero_out  = zero_q;
  assign bus.mant_out  = mant_q;
  assign bus.exp_off   = exp_q;

  // next state: accept, shift until MSB set, hold until consumed
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgnr_d  = sgnr_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.valid_in) begin
          mag_d  = abs_w;
          sgnr_d = bus.data_in[W-1];
          cnt_d  = '0;
          if (bus.data_in == '0) begin
            state_d = S_DONE;
            zero_d  = 1'b1;
            sign_d  = 1'b0;
            mant_d  = '0;
            exp_d   = '0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      (state_q == S_SHIFT): begin
        if (mag_q[W-1]) begin
          state_d = S_DONE;
          sign_d  = sgnr_q;
          zero_d  = 1'b0;
          mant_d  = mag_q[W-2 -: M];
          exp_d   = EXP_W'(exp_offset(W, FRAC, int'(cnt_q)));
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == S_DONE): begin
        if (bus.ready_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sgnr_q  <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sgnr_q  <= sgnr_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
    end
  end

endmodule
